// File: rtl/memory_access_stage.sv
// memory_access_stage: M stage of the 5-stage pipeline. It runs loads and stores on a
// variable-latency req/ack data port and stalls upstream while an access is outstanding.
// Hung accesses are aborted after TIMEOUT cycles, and misaligned word accesses are
// rejected without a request. It also loads the M/W pipeline register.
//
// state  | meaning
// S_IDLE | no access outstanding; non-memory ops and misaligned ops pass in one cycle
// S_BUSY | mem_req held high, waiting for mem_ack or the timeout counter to expire
module memory_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        BusErrW,
  output logic        MisalignW
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Last counter value at which a missing ack still waits; at this value the access aborts.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_memop;
  logic             w_aligned;
  logic             w_is_load;

  // M/W register controls: w_wload captures the M inputs, otherwise a bubble is inserted.
  logic             w_wload;
  logic             w_wregwr;
  logic [31:0]      w_wrdata;
  logic             w_wbuserr;
  logic             w_wmisalign;

  assign w_memop   = MemWriteM | ResultSrcM;
  assign w_aligned = (ALU_ResultM[1:0] == 2'b00);
  // A store wins when both MemWriteM and ResultSrcM are set.
  assign w_is_load = ResultSrcM & ~MemWriteM;

  assign mem_we    = mem_req & MemWriteM;
  assign mem_addr  = ALU_ResultM;
  assign mem_wdata = WriteDataM;

  // State register and timeout counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, handshake, stall and M/W load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    StallM      = 1'b0;
    mem_req     = 1'b0;
    w_wload     = 1'b0;
    w_wregwr    = 1'b0;
    w_wrdata    = '0;
    w_wbuserr   = 1'b0;
    w_wmisalign = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_memop) begin
          w_wload  = 1'b1;
          w_wregwr = RegWriteM;
        end else if (!w_aligned) begin
          // Faulted op retires with its write enable suppressed.
          w_wload     = 1'b1;
          w_wmisalign = 1'b1;
        end else begin
          StallM      = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = '0;
        end
      end
      S_BUSY: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_wload     = 1'b1;
          w_wregwr    = RegWriteM;
          w_wrdata    = w_is_load ? mem_rdata : 32'h0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_wload     = 1'b1;
          w_wbuserr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          StallM    = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // M/W pipeline register: capture on retire, otherwise a bubble that never repeats a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      BusErrW     <= 1'b0;
      MisalignW   <= 1'b0;
    end else if (w_wload) begin
      RegWriteW   <= w_wregwr;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= w_wrdata;
      BusErrW     <= w_wbuserr;
      MisalignW   <= w_wmisalign;
    end else begin
      RegWriteW   <= 1'b0;
      BusErrW     <= 1'b0;
      MisalignW   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed ops with a scoreboard of expected M/W contents.
module tb_memory_access_stage;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        BusErrW, MisalignW;

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        be;
    logic        ma;
  } wexp_t;

  wexp_t sb[$];
  int    n_err = 0;
  int    n_chk = 0;

  memory_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .BusErrW(BusErrW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_w(input string nm);
    wexp_t e;
    if (sb.size() == 0) begin
      chk({nm, "/sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({nm, "/RegWriteW"},   RegWriteW,   e.rw);
    chk({nm, "/ResultSrcW"},  ResultSrcW,  e.rs);
    chk({nm, "/RD_W"},        RD_W,        e.rd);
    chk({nm, "/PCPlus4W"},    PCPlus4W,    e.pc);
    chk({nm, "/ALU_ResultW"}, ALU_ResultW, e.alu);
    chk({nm, "/ReadDataW"},   ReadDataW,   e.rdata);
    chk({nm, "/BusErrW"},     BusErrW,     e.be);
    chk({nm, "/MisalignW"},   MisalignW,   e.ma);
  endtask

  // Issue one op (called at posedge+1); ack_at = BUSY cycle index that acks, 0 = never.
  task automatic run_op(input string nm, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                        input logic [31:0] addr, input int ack_at, input logic [31:0] rdata);
    wexp_t e;
    int    exp_req;
    int    req_n  = 0;
    int    stall_n = 0;
    int    bidx   = 0;
    bit    done   = 0;
    e.rw = rw; e.rs = rs; e.rd = rd; e.pc = pc; e.alu = addr;
    e.rdata = 32'h0; e.be = 1'b0; e.ma = 1'b0;
    if (!(mw | rs)) begin
      exp_req = 0;
    end else if (addr[1:0] != 2'b00) begin
      exp_req = 0; e.rw = 1'b0; e.ma = 1'b1;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
      exp_req = ack_at;
      if (!mw) e.rdata = rdata;
    end else begin
      exp_req = TIMEOUT; e.rw = 1'b0; e.be = 1'b1;
    end
    sb.push_back(e);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = addr;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        bidx++;
        req_n++;
        if (bidx == 1) begin
          chk({nm, "/mem_we"},    mem_we,    mw);
          chk({nm, "/mem_addr"},  mem_addr,  addr);
          chk({nm, "/mem_wdata"}, mem_wdata, wd);
        end
        mem_ack   = (bidx == ack_at);
        mem_rdata = mem_ack ? rdata : (32'hBAD0_0000 ^ 32'(bidx));
      end
      #1;
      if (StallM) stall_n++;
      else done = 1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!done) begin
        chk({nm, "/bubble_RegWriteW"}, RegWriteW, 1'b0);
        chk({nm, "/bubble_BusErrW"},   BusErrW,   1'b0);
        chk({nm, "/bubble_MisalignW"}, MisalignW, 1'b0);
      end
    end
    if (!done) begin
      chk({nm, "/cycle_bound"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      cmp_w(nm);
    end
    chk({nm, "/req_cycles"},   req_n,   exp_req);
    chk({nm, "/stall_cycles"}, stall_n, exp_req);
  endtask

  initial begin
    wexp_t e;
    rst = 1'b0;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = 5'd3;
    PCPlus4M = 32'h44; WriteDataM = 32'h55; ALU_ResultM = 32'h66;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/mem_req",     mem_req,     1'b0);
    chk("reset/RegWriteW",   RegWriteW,   1'b0);
    chk("reset/RD_W",        RD_W,        5'd0);
    chk("reset/PCPlus4W",    PCPlus4W,    32'h0);
    chk("reset/ALU_ResultW", ALU_ResultW, 32'h0);
    chk("reset/BusErrW",     BusErrW,     1'b0);
    chk("reset/MisalignW",   MisalignW,   1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_op("add",     1'b1, 1'b0, 1'b0, 5'd5,  32'h104, 32'h0,    32'h10, 0, 32'h0);
    run_op("lw3",     1'b1, 1'b0, 1'b1, 5'd7,  32'h108, 32'h0,    32'h20, 3, 32'hDEADBEEF);
    run_op("nop",     1'b0, 1'b0, 1'b0, 5'd0,  32'h10C, 32'h0,    32'h0,  0, 32'h0);
    run_op("sw1",     1'b0, 1'b1, 1'b0, 5'd0,  32'h110, 32'h1234, 32'h24, 1, 32'h0);
    run_op("lw_mis",  1'b1, 1'b0, 1'b1, 5'd8,  32'h114, 32'h0,    32'h22, 1, 32'h0);
    run_op("sw_mis",  1'b0, 1'b1, 1'b0, 5'd0,  32'h118, 32'h77,   32'h25, 1, 32'h0);
    run_op("lw_to",   1'b1, 1'b0, 1'b1, 5'd9,  32'h11C, 32'h0,    32'h30, 0, 32'h0);
    run_op("sw_b2b",  1'b0, 1'b1, 1'b0, 5'd0,  32'h120, 32'hA5A5, 32'h34, 2, 32'h0);
    run_op("lw_b2b",  1'b1, 1'b0, 1'b1, 5'd10, 32'h124, 32'h0,    32'h38, 1, 32'h13579BDF);
    run_op("lw_last", 1'b1, 1'b0, 1'b1, 5'd11, 32'h128, 32'h0,    32'h3C, TIMEOUT, 32'h2468ACE0);
    run_op("swlw",    1'b1, 1'b1, 1'b1, 5'd12, 32'h12C, 32'h99,   32'h44, 1, 32'hFFFF0000);

    // Reset in the middle of an access, then an ack that arrives while IDLE.
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; RD_M = 5'd9;
    PCPlus4M = 32'h200; WriteDataM = 32'h0; ALU_ResultM = 32'h40;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst/busy1_req", mem_req, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst/busy2_req", mem_req, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst/mem_req",     mem_req,     1'b0);
    chk("rst/StallM",      StallM,      1'b1);
    chk("rst/RegWriteW",   RegWriteW,   1'b0);
    chk("rst/ResultSrcW",  ResultSrcW,  1'b0);
    chk("rst/RD_W",        RD_W,        5'd0);
    chk("rst/PCPlus4W",    PCPlus4W,    32'h0);
    chk("rst/ALU_ResultW", ALU_ResultW, 32'h0);
    chk("rst/ReadDataW",   ReadDataW,   32'h0);
    e.rw = 1'b1; e.rs = 1'b1; e.rd = 5'd9; e.pc = 32'h200; e.alu = 32'h40;
    e.rdata = 32'h600DF00D; e.be = 1'b0; e.ma = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("rst/idle_ack_ReadDataW", ReadDataW, 32'h0);
    chk("rst/idle_ack_RegWriteW", RegWriteW, 1'b0);
    @(negedge clk);
    chk("rst/retry_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 32'h600DF00D;
    #1;
    chk("rst/retry_StallM", StallM, 1'b0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    cmp_w("rst/retry");

    run_op("lw_after", 1'b1, 1'b0, 1'b1, 5'd13, 32'h204, 32'h0, 32'h48, 2, 32'h0BADCAFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
